// File: rtl/fp_add_norm_round_if.sv
// Handshake and data bundle between the add/subtract datapath, the
// normalize/round stage and its consumer.
interface fp_add_norm_round_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    localparam int M_W = FRAC_W + 5;
    localparam int R_W = 1 + EXP_W + FRAC_W;

    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [M_W-1:0]   in_mant;
    logic             in_special;
    logic [R_W-1:0]   in_special_res;
    logic             out_valid;
    logic             out_ready;
    logic [R_W-1:0]   res;
    logic             exception;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_special, in_special_res, out_ready,
        input  in_ready, out_valid, res, exception
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_special, in_special_res, out_ready,
        output in_ready, out_valid, res, exception
    );
endinterface

// File: rtl/fp_add_norm_round.sv
// Post-add stage: normalizes the raw sum one bit per cycle, rounds to
// nearest-even and packs an IEEE-754 result with an overflow/special flag.
module fp_add_norm_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input logic               clk,
    input logic               rst,
    fp_add_norm_round_if.slave bus
);
    localparam int M_W = FRAC_W + 5;
    localparam int R_W = 1 + EXP_W + FRAC_W;
    localparam int E_W = EXP_W + 2;
    localparam int C_W = $clog2(M_W);
    localparam logic [C_W-1:0] MAX_SHIFT = C_W'(M_W - 2);
    localparam logic [E_W-1:0] EXP_MAX   = E_W'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_NORM, ST_ROUND, ST_OUT} state_t;

    state_t         r_state, w_state_nxt;
    logic           r_sign, w_sign_nxt;
    logic [E_W-1:0] r_exp, w_exp_nxt;
    logic [M_W-1:0] r_mant, w_mant_nxt;
    logic [C_W-1:0] r_cnt, w_cnt_nxt;
    logic [R_W-1:0] r_res, w_res_nxt;
    logic           r_exc, w_exc_nxt;

    logic              w_round_up;
    logic [FRAC_W+1:0] w_sum;
    logic [E_W-1:0]    w_rnd_exp;
    logic [FRAC_W-1:0] w_rnd_frac;
    logic              w_rnd_hidden;
    logic [EXP_W-1:0]  w_exp_field;
    logic              w_ovf;

    // Round-to-nearest-even on {hidden, fraction}; a carry out renormalizes by one.
    assign w_round_up   = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
    assign w_sum        = {1'b0, r_mant[M_W-2:3]} + {{(FRAC_W+1){1'b0}}, w_round_up};
    assign w_rnd_exp    = w_sum[FRAC_W+1] ? r_exp + E_W'(1) : r_exp;
    assign w_rnd_frac   = w_sum[FRAC_W+1] ? w_sum[FRAC_W:1] : w_sum[FRAC_W-1:0];
    assign w_rnd_hidden = w_sum[FRAC_W+1] | w_sum[FRAC_W];
    assign w_exp_field  = w_rnd_hidden ? w_rnd_exp[EXP_W-1:0] : '0;
    assign w_ovf        = (w_rnd_exp >= EXP_MAX);

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_OUT);
    assign bus.res       = r_res;
    assign bus.exception = r_exc;

    always_comb begin
        // NOTE: every next-state value defaults to its register so no path infers a latch.
        w_state_nxt = r_state;
        w_sign_nxt  = r_sign;
        w_exp_nxt   = r_exp;
        w_mant_nxt  = r_mant;
        w_cnt_nxt   = r_cnt;
        w_res_nxt   = r_res;
        w_exc_nxt   = r_exc;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_special) begin
                        w_res_nxt   = bus.in_special_res;
                        w_exc_nxt   = 1'b1;
                        w_state_nxt = ST_OUT;
                    end else if (bus.in_mant == '0) begin
                        w_res_nxt   = {bus.in_sign, {(R_W-1){1'b0}}};
                        w_exc_nxt   = 1'b0;
                        w_state_nxt = ST_OUT;
                    end else begin
                        w_sign_nxt  = bus.in_sign;
                        w_exp_nxt   = (bus.in_exp == '0) ? E_W'(1) : E_W'(bus.in_exp);
                        w_mant_nxt  = bus.in_mant;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                if (r_mant[M_W-1]) begin
                    w_mant_nxt  = {1'b0, r_mant[M_W-1:2], r_mant[1] | r_mant[0]};
                    w_exp_nxt   = r_exp + E_W'(1);
                    w_state_nxt = ST_ROUND;
                end else if (r_mant[M_W-2]) begin
                    w_state_nxt = ST_ROUND;
                end else if (r_exp > E_W'(1) && r_cnt < MAX_SHIFT) begin
                    w_mant_nxt = {r_mant[M_W-2:0], 1'b0};
                    w_exp_nxt  = r_exp - E_W'(1);
                    w_cnt_nxt  = r_cnt + C_W'(1);
                end else begin
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (w_ovf) begin
                    w_res_nxt = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    w_exc_nxt = 1'b1;
                end else begin
                    w_res_nxt = {r_sign, w_exp_field, w_rnd_frac};
                    w_exc_nxt = 1'b0;
                end
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_mant  <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_exc   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sign  <= w_sign_nxt;
            r_exp   <= w_exp_nxt;
            r_mant  <= w_mant_nxt;
            r_cnt   <= w_cnt_nxt;
            r_res   <= w_res_nxt;
            r_exc   <= w_exc_nxt;
        end
    end
endmodule

// File: tb/tb_fp_add_norm_round.sv
// Directed bench for fp_add_norm_round: hand-computed single-precision
// results, latencies, backpressure and asynchronous reset.
module tb_fp_add_norm_round;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    fp_add_norm_round_if #(.EXP_W(8), .FRAC_W(23)) bus ();

    fp_add_norm_round #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one operation, measure latency, optionally hold off out_ready, then retire.
    task automatic run_op(input string tag, input logic sgn, input logic [7:0] e,
                          input logic [27:0] m, input logic sp, input logic [31:0] spr,
                          input logic [31:0] exp_res, input logic exp_exc,
                          input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid       = 1'b1;
        bus.in_sign        = sgn;
        bus.in_exp         = e;
        bus.in_mant        = m;
        bus.in_special     = sp;
        bus.in_special_res = spr;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " res"}, 64'(bus.res), 64'(exp_res));
        check({tag, " exception"}, 64'(bus.exception), 64'(exp_exc));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " held out_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, " held res"}, 64'(bus.res), 64'(exp_res));
            check({tag, " held in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " retired out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, " retired in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid       = 1'b0;
        bus.in_sign        = 1'b0;
        bus.in_exp         = '0;
        bus.in_mant        = '0;
        bus.in_special     = 1'b0;
        bus.in_special_res = '0;
        bus.out_ready      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset res", 64'(bus.res), 64'd0);
        check("reset exception", 64'(bus.exception), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("one_plus_one", 1'b0, 8'd127, 28'h8000000, 1'b0, 32'h0, 32'h40000000, 1'b0, 3, 0);
        run_op("cancel", 1'b0, 8'd127, 28'h0000008, 1'b0, 32'h0, 32'h34000000, 1'b0, 26, 0);
        run_op("tie_odd", 1'b0, 8'd127, {1'b0, 24'h800001, 3'b100}, 1'b0, 32'h0, 32'h3F800002, 1'b0, 3, 0);
        run_op("tie_even", 1'b0, 8'd127, {1'b0, 24'h800000, 3'b100}, 1'b0, 32'h0, 32'h3F800000, 1'b0, 3, 0);
        run_op("rnd_carry", 1'b0, 8'd127, {1'b0, 24'hFFFFFF, 3'b100}, 1'b0, 32'h0, 32'h40000000, 1'b0, 3, 0);
        run_op("sticky_shift", 1'b0, 8'd127, 28'h8000009, 1'b0, 32'h0, 32'h40000001, 1'b0, 3, 0);
        run_op("overflow", 1'b0, 8'd254, 28'h8000000, 1'b0, 32'h0, 32'h7F800000, 1'b1, 3, 0);
        run_op("neg_zero", 1'b1, 8'd90, 28'h0, 1'b0, 32'h0, 32'h80000000, 1'b0, 1, 0);
        run_op("special", 1'b0, 8'd0, 28'h0, 1'b1, 32'h7FC00000, 32'h7FC00000, 1'b1, 1, 0);
        run_op("to_subnorm", 1'b0, 8'd3, {1'b0, 24'h100000, 3'b000}, 1'b0, 32'h0, 32'h00400000, 1'b0, 5, 0);
        run_op("subnorm_rnd", 1'b1, 8'd0, {1'b0, 24'h7FFFFF, 3'b100}, 1'b0, 32'h0, 32'h80800000, 1'b0, 3, 0);
        run_op("backpressure", 1'b0, 8'd127, 28'h8000000, 1'b0, 32'h0, 32'h40000000, 1'b0, 3, 5);

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 8'd127;
        bus.in_mant  = 28'h0000008;
        bus.in_special = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midnorm rst out_valid", 64'(bus.out_valid), 64'd0);
        check("midnorm rst in_ready", 64'(bus.in_ready), 64'd1);
        check("midnorm rst res", 64'(bus.res), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 1'b0, 8'd127, {1'b0, 24'h800001, 3'b100}, 1'b0, 32'h0, 32'h3F800002, 1'b0, 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_add_norm_round.md
Name: fp_add_norm_round

Overview:
- Sequential post-add stage directly downstream of the single-precision add/subtract datapath.
- Consumes the raw signed-magnitude sum from that datapath: sign, effective exponent, and an unnormalized mantissa carrying guard/round/sticky bits.
- Normalizes one bit position per cycle, rounds to nearest-even, and packs an IEEE-754 result with an overflow/special exception flag.
- Valid/ready handshakes on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, fraction field width. Internal mantissa width M_W = FRAC_W+5.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream sum valid.
- in_ready  output  1  stage can accept (high only in IDLE).
- in_sign  input  1  result sign resolved upstream.
- in_exp  input  EXP_W  biased exponent of larger operand; 0 is treated as 1 at capture.
- in_mant  input  M_W  [M_W-1]=carry, [M_W-2]=hidden, [M_W-3:3]=fraction, [2]=G, [1]=R, [0]=S.
- in_special  input  1  upstream detected NaN/Inf; bypass normalization.
- in_special_res  input  1+EXP_W+FRAC_W  packed result used when in_special=1.
- out_valid  output  1  res/exception valid.
- out_ready  input  1  downstream accepts.
- res  output  1+EXP_W+FRAC_W  packed IEEE result.
- exception  output  1  overflow to Inf, or special bypass.

Behaviour:
- Reset (async, any state, including mid-NORM): state=IDLE, in_ready=1, out_valid=0, res=0, exception=0, internal regs cleared.
- Handshake: a transfer occurs on in_valid&&in_ready. in_ready is high only in IDLE. out_valid holds, with res/exception stable, until out_ready is sampled high; then the state returns to IDLE. No accept happens in the same cycle as output retire, so there is one bubble per operation.
- States:
  - IDLE, on accept:
    - in_special: res=in_special_res, exception=1, next OUT.
    - in_mant==0: res={in_sign, all zeros}, exception=0, next OUT.
    - otherwise: capture sign/exp/mant, next NORM.
  - NORM, exactly one action per cycle:
    - carry bit set: shift right 1, S |= shifted-out bit, exp+1, next ROUND.
    - hidden bit set: next ROUND.
    - hidden bit clear and exp>1: shift left 1 (zero fill into S), exp-1, stay.
    - hidden bit clear and exp==1: subnormal, next ROUND.
    - Bounded to at most M_W-2 left-shift cycles.
  - ROUND:
    - Round to nearest-even: up = G & (R | S | LSB). Add up to {hidden, fraction}.
    - Carry out of the hidden position: shift right 1, exp+1.
    - Exponent field = 0 if hidden bit is 0 (subnormal), else exp. A subnormal rounding into the hidden bit yields exponent field 1.
    - If exp >= 2^EXP_W-1: res={sign, all ones, zeros}, exception=1. Otherwise res={sign, expfield, fraction}, exception=0.
    - Next OUT.
  - OUT: out_valid=1; on out_ready, next IDLE with out_valid=0 the following cycle.
- Latency (accept edge to out_valid high):
  - Special/zero: 1 cycle.
  - Carry or already-normal: 3 cycles.
  - k left shifts: 3+k cycles.
- res/exception are registered outputs; they change only on the ROUND→OUT or IDLE→OUT transitions.

Test Plan:
- 1.0+1.0: sign=0, exp=127, mant carry bit only (28'h8000000) → res=0x40000000, exception=0, out_valid 3 cycles after accept.
- Cancellation: exp=127, mant=28'h0000008 (fraction LSB only) → 23 NORM shift cycles → res=0x34000000 at 26 cycles.
- Ties, nearest-even:
  - exp=127, {hidden, frac}=0x800001, G=1, R=S=0 → res=0x3F800002.
  - Same with {hidden, frac}=0x800000 → res=0x3F800000.
- Round carry-out: exp=127, {hidden, frac}=0xFFFFFF, G=1 → res=0x40000000. Overflow: exp=254 with carry bit → res=0x7F800000, exception=1.
- Zero/special:
  - mant=0, sign=1 → 0x80000000 after 1 cycle.
  - in_special=1, in_special_res=0x7FC00000 → same value, exception=1.
- Backpressure and reset:
  - out_ready=0 for 5 cycles → res stable, in_ready=0; retire on out_ready=1.
  - Assert rst during NORM → out_valid=0, in_ready=1 immediately; the next operation completes correctly.
